// File: rtl/mpcache_pkg.sv
// rtl/mpcache_pkg.sv - shared constants and types for the multi-port cache write path
`ifndef BLK_ADDR_WIDTH
`define BLK_ADDR_WIDTH 10
`endif

package mpcache_pkg;
    localparam int NUM_PORTS = 16;
    localparam int NUM_BLKS  = 64;
    localparam int BLK_WORDS = 16;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    typedef logic [$clog2(NUM_BLKS)-1:0] blk_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first request at or above ptr wins
module rr_arbiter #(
    parameter int N     = 16,
    parameter int PTR_W = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);
    always_comb begin
        int  idx;
        logic found;
        o_gnt = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(i_ptr) + i) % N;
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/blk_addr_alloc.sv
// rtl/blk_addr_alloc.sv - free-block pool and round-robin block-address allocator
module blk_addr_alloc #(
    parameter int NUM_PORTS = mpcache_pkg::NUM_PORTS,
    parameter int NUM_BLKS  = mpcache_pkg::NUM_BLKS,
    parameter int BLK_WORDS = mpcache_pkg::BLK_WORDS,
    parameter int ADDR_W    = `BLK_ADDR_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_PORTS-1:0]        i_addr_req,
    output logic [NUM_PORTS-1:0]        o_blk_addr_vld,
    output logic [ADDR_W-1:0]           o_blk_addr,
    input  logic                        i_free_vld,
    input  logic [ADDR_W-1:0]           i_free_addr,
    output logic [$clog2(NUM_BLKS):0]   o_free_cnt,
    output logic                        o_init_done,
    output logic                        o_req_ovf,
    output logic                        o_free_ovf
);
    import mpcache_pkg::*;

    localparam int IDX_W = $clog2(NUM_BLKS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFS_W = $clog2(BLK_WORDS);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e               state_q;
    logic [IDX_W-1:0]     pool_q [NUM_BLKS];
    logic [IDX_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] pend_q, pend_d, arb_gnt, gnt;
    logic [PTR_W-1:0]     rr_ptr_q, win_idx;
    logic [NUM_PORTS-1:0] vld_q;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 init_done_q, req_ovf_q, free_ovf_q;
    logic                 pop, push, drop, full;
    logic [IDX_W-1:0]     free_idx;
    logic                 unused_free_bits;

    rr_arbiter #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
        .i_req (pend_q),
        .i_ptr (rr_ptr_q),
        .o_gnt (arb_gnt)
    );

    assign free_idx         = i_free_addr[OFS_W +: IDX_W];
    assign unused_free_bits = ^i_free_addr;

    always_comb begin
        full    = (cnt_q == CNT_W'(NUM_BLKS));
        pop     = (state_q == S_RUN) && (cnt_q != '0) && (|pend_q);
        gnt     = pop ? arb_gnt : '0;
        // Full-pool returns are dropped even if a pop happens in the same cycle.
        push    = (state_q == S_RUN) && i_free_vld && !full;
        drop    = (state_q == S_RUN) && i_free_vld && full;
        cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
        pend_d  = (pend_q & ~gnt) | i_addr_req;
        addr_d  = pop ? (ADDR_W'(pool_q[rd_ptr_q]) << OFS_W) : '0;
        win_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) win_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_INIT;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            vld_q       <= '0;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            req_ovf_q   <= 1'b0;
            free_ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= gnt;
            addr_q <= addr_d;
            if (|(i_addr_req & pend_q & ~gnt)) req_ovf_q <= 1'b1;
            case (state_q)
                S_INIT: begin
                    pool_q[wr_ptr_q] <= wr_ptr_q;
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                    cnt_q            <= cnt_q + 1'b1;
                    if (wr_ptr_q == IDX_W'(NUM_BLKS - 1)) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        rr_ptr_q <= (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
                    end
                    if (push) begin
                        pool_q[wr_ptr_q] <= free_idx;
                        wr_ptr_q         <= wr_ptr_q + 1'b1;
                    end
                    if (drop) free_ovf_q <= 1'b1;
                    cnt_q <= cnt_d;
                end
            endcase
        end
    end

    assign o_blk_addr_vld = vld_q;
    assign o_blk_addr     = addr_q;
    assign o_free_cnt     = cnt_q;
    assign o_init_done    = init_done_q;
    assign o_req_ovf      = req_ovf_q;
    assign o_free_ovf     = free_ovf_q;
endmodule

// File: tb/tb_blk_addr_alloc.sv
// tb/tb_blk_addr_alloc.sv - directed self-checking bench for blk_addr_alloc
module tb_blk_addr_alloc;
    localparam int NP = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] vld;
    logic [AW-1:0] addr;
    logic          free_vld = 1'b0;
    logic [AW-1:0] free_addr = '0;
    logic [6:0]    free_cnt;
    logic          init_done, req_ovf, free_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    blk_addr_alloc #(.NUM_PORTS(16), .NUM_BLKS(64), .BLK_WORDS(16), .ADDR_W(AW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_addr_req     (req),
        .o_blk_addr_vld (vld),
        .o_blk_addr     (addr),
        .i_free_vld     (free_vld),
        .i_free_addr    (free_addr),
        .o_free_cnt     (free_cnt),
        .o_init_done    (init_done),
        .o_req_ovf      (req_ovf),
        .o_free_ovf     (free_ovf)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic reset_and_init(output int cyc);
        rst = 1'b1; req = '0; free_vld = 1'b0; free_addr = '0;
        tick; tick;
        rst = 1'b0;
        cyc = 0;
        while (!init_done && cyc < 200) begin tick; cyc++; end
    endtask

    task automatic test_reset;
        int n;
        int saw;
        rst = 1'b1; req = '0; free_vld = 1'b0;
        tick; tick;
        checks++;
        if (vld !== '0 || addr !== '0) begin
            failures++; $display("FAIL reset_grant vld=%h addr=%h expected 0/0", vld, addr);
        end
        checks++;
        if (free_cnt !== 7'd0 || init_done !== 1'b0 || req_ovf !== 1'b0 || free_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_status cnt=%0d done=%b rovf=%b fovf=%b expected 0", free_cnt, init_done, req_ovf, free_ovf);
        end
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 200) begin tick; n++; end
        checks++;
        if (n !== 64) begin
            failures++; $display("FAIL init_latency got=%0d expected=64", n);
        end
        checks++;
        if (free_cnt !== 7'd64) begin
            failures++; $display("FAIL init_cnt got=%0d expected=64", free_cnt);
        end
        saw = 0;
        repeat (5) begin tick; if (vld !== '0) saw++; end
        checks++;
        if (saw !== 0) begin
            failures++; $display("FAIL idle_grants got=%0d expected=0", saw);
        end
    endtask

    task automatic test_single_port;
        req = 16'h0008; tick; req = '0;
        checks++;
        if (vld !== '0) begin
            failures++; $display("FAIL single_early vld=%h expected 0", vld);
        end
        tick;
        checks++;
        if (vld !== 16'h0008 || addr !== 10'h000) begin
            failures++; $display("FAIL single_first vld=%h addr=%h expected 0008/000", vld, addr);
        end
        tick;
        checks++;
        if (vld !== '0 || addr !== '0) begin
            failures++; $display("FAIL single_once vld=%h addr=%h expected 0/0", vld, addr);
        end
        req = 16'h0008; tick; req = '0; tick;
        checks++;
        if (vld !== 16'h0008 || addr !== 10'h010) begin
            failures++; $display("FAIL single_second vld=%h addr=%h expected 0008/010", vld, addr);
        end
    endtask

    task automatic test_all_ports;
        int n;
        logic [NP-1:0] ev;
        logic [AW-1:0] ea;
        reset_and_init(n);
        req = '1; tick; req = '0;
        for (int i = 0; i < NP; i++) begin
            tick;
            ev = 16'h0001 << i;
            ea = AW'(i * 16);
            checks++;
            if (vld !== ev || addr !== ea) begin
                failures++; $display("FAIL rr_grant%0d vld=%h addr=%h expected %h/%h", i, vld, addr, ev, ea);
            end
        end
        tick;
        checks++;
        if (vld !== '0 || free_cnt !== 7'd48) begin
            failures++; $display("FAIL rr_after vld=%h cnt=%0d expected 0/48", vld, free_cnt);
        end
    endtask

    task automatic test_drain_and_return;
        int ngr;
        int saw;
        logic [AW-1:0] last;
        ngr = 0; last = '0;
        for (int i = 0; i < 52; i++) begin
            req = (i < 48) ? (16'h0001 << (i % 16)) : '0;
            tick;
            if (vld !== '0) begin ngr++; last = addr; end
        end
        req = '0;
        checks++;
        if (ngr !== 48 || last !== 10'h3F0 || free_cnt !== 7'd0) begin
            failures++; $display("FAIL drain grants=%0d last=%h cnt=%0d expected 48/3f0/0", ngr, last, free_cnt);
        end
        req = 16'h0020; tick; req = '0;
        saw = 0;
        repeat (10) begin tick; if (vld !== '0) saw++; end
        checks++;
        if (saw !== 0) begin
            failures++; $display("FAIL empty_stall grants=%0d expected 0", saw);
        end
        free_vld = 1'b1; free_addr = 10'h2A0; tick; free_vld = 1'b0;
        checks++;
        if (vld !== '0 || free_cnt !== 7'd1) begin
            failures++; $display("FAIL no_bypass vld=%h cnt=%0d expected 0/1", vld, free_cnt);
        end
        tick;
        checks++;
        if (vld !== 16'h0020 || addr !== 10'h2A0 || free_cnt !== 7'd0) begin
            failures++; $display("FAIL return_grant vld=%h addr=%h cnt=%0d expected 0020/2a0/0", vld, addr, free_cnt);
        end
    endtask

    task automatic test_req_ovf;
        int ngr;
        logic [AW-1:0] last;
        logic [NP-1:0] lastv;
        checks++;
        if (req_ovf !== 1'b0) begin
            failures++; $display("FAIL req_ovf_pre got=%b expected 0", req_ovf);
        end
        req = 16'h0004; tick; tick; req = '0; tick;
        checks++;
        if (req_ovf !== 1'b1) begin
            failures++; $display("FAIL req_ovf_set got=%b expected 1", req_ovf);
        end
        free_vld = 1'b1; free_addr = 10'h15A; tick; free_vld = 1'b0;
        ngr = 0; last = '0; lastv = '0;
        repeat (6) begin
            tick;
            if (vld !== '0) begin ngr++; last = addr; lastv = vld; end
        end
        checks++;
        if (ngr !== 1 || lastv !== 16'h0004 || last !== 10'h150) begin
            failures++; $display("FAIL merged_grant n=%0d vld=%h addr=%h expected 1/0004/150", ngr, lastv, last);
        end
    endtask

    task automatic test_free_ovf_and_reset;
        int n;
        int saw;
        reset_and_init(n);
        checks++;
        if (free_ovf !== 1'b0 || req_ovf !== 1'b0) begin
            failures++; $display("FAIL sticky_cleared fovf=%b rovf=%b expected 0/0", free_ovf, req_ovf);
        end
        free_vld = 1'b1; free_addr = 10'h000; tick; free_vld = 1'b0; tick;
        checks++;
        if (free_ovf !== 1'b1 || free_cnt !== 7'd64) begin
            failures++; $display("FAIL free_ovf fovf=%b cnt=%0d expected 1/64", free_ovf, free_cnt);
        end
        req = '1; tick; req = '0; tick; tick;
        checks++;
        if (vld !== 16'h0002 || addr !== 10'h010) begin
            failures++; $display("FAIL burst_mid vld=%h addr=%h expected 0002/010", vld, addr);
        end
        rst = 1'b1; tick;
        checks++;
        if (vld !== '0 || addr !== '0 || free_cnt !== 7'd0 || init_done !== 1'b0 || free_ovf !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset vld=%h addr=%h cnt=%0d done=%b fovf=%b expected all 0", vld, addr, free_cnt, init_done, free_ovf);
        end
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 200) begin tick; n++; end
        checks++;
        if (n !== 64) begin
            failures++; $display("FAIL reinit_latency got=%0d expected=64", n);
        end
        saw = 0;
        repeat (5) begin tick; if (vld !== '0) saw++; end
        checks++;
        if (saw !== 0 || free_cnt !== 7'd64) begin
            failures++; $display("FAIL pending_discarded grants=%0d cnt=%0d expected 0/64", saw, free_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_single_port;
        test_all_ports;
        test_drain_and_return;
        test_req_ovf;
        test_free_ovf_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
